multicycle_control_unit: RTL and testbench

//  Multicycle RV32I control FSM: the producer side of the ALU interface. Drives alu_operation
//  and operand/result selects into the datapath, consumes the ALU {n,z,c,v} status for branches.

---
 rtl/multicycle_control_unit_pkg.sv | 19 +
 rtl/multicycle_control_unit_alu_decoder.sv | 22 ++
 rtl/multicycle_control_unit.sv | 115 +++++++++++
 tb/tb_multicycle_control_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// rv32i_defs: shared types and opcodes for the multicycle RV32I control unit
package rv32i_defs;
  localparam int OperandSize = 32;
  typedef enum logic [2:0] {SUM, SUB, SLT, OR, AND} alu_opcode_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE,
    EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP
  } mcu_state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD_PC, SRC_A_RS1} src_a_t;
  typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_MEM, RES_ALU} result_src_t;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: funct3/funct7_5 to ALU operation, flags unsupported encodings
//   op5 (opcode[5], 1=R-type), funct3, funct7_5, branch -> alu_operation, unsupported
module alu_decoder
  import rv32i_defs::*;
(
  input  logic        op5,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        branch,
  output alu_opcode_t alu_operation,
  output logic        unsupported
);
  // branches always compare by subtraction; only beq/bne/blt/bge (funct3[1]=0) exist
  always_comb begin
    alu_operation = branch ? SUB :
                    funct3 == 3'b000 ? (op5 && funct7_5 ? SUB : SUM) :
                    funct3 == 3'b010 ? SLT :
                    funct3 == 3'b110 ? OR :
                    funct3 == 3'b111 ? AND : SUM;
    unsupported = branch ? funct3[1] : !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RV32I control FSM driving the datapath selects and ALU
//   in:  clk, rstn (async, active low), opcode, funct3, funct7_5, status {n,z,c,v}, mem_ready
//   out: pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b,
//        imm_src, alu_operation, illegal
module multicycle_control_unit
  import rv32i_defs::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output result_src_t result_src,
  output src_a_t      alu_src_a,
  output src_b_t      alu_src_b,
  output imm_src_t    imm_src,
  output alu_opcode_t alu_operation,
  output logic        illegal
);
  mcu_state_t  state;
  alu_opcode_t dec_op;
  logic        dec_bad, taken, unused_c;
  alu_decoder u_dec (
    .op5(opcode[5]), .funct3(funct3), .funct7_5(funct7_5), .branch(state == BRANCH),
    .alu_operation(dec_op), .unsupported(dec_bad)
  );
  assign unused_c = status[1];
  // funct3[0] inverts the sense (bne/bge), funct3[2] picks signed-less-than over zero
  assign taken = !funct3[1] && (funct3[0] ^ (funct3[2] ? status[3] ^ status[0] : status[2]));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= FETCH;
    else
      case (state)
        FETCH:          if (mem_ready) state <= DECODE;
        DECODE:         state <= (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADR :
                                 opcode == OP_R ? EXEC_R : opcode == OP_IMM ? EXEC_I :
                                 opcode == OP_BRANCH ? BRANCH : opcode == OP_JAL ? JAL : TRAP;
        MEM_ADR:        state <= opcode == OP_STORE ? MEM_WRITE : MEM_READ;
        MEM_READ:       if (mem_ready) state <= MEM_WB;
        MEM_WRITE:      if (mem_ready) state <= FETCH;
        EXEC_R, EXEC_I: state <= dec_bad ? FETCH : ALU_WB;
        JAL:            state <= ALU_WB;
        default:        state <= FETCH;
      endcase
  // outputs decode from state; reset forces them all to their idle values immediately
  always_comb begin
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    imm_src = IMM_I;
    alu_operation = SUM;
    illegal = 1'b0;
    if (rstn) begin
      imm_src = opcode == OP_STORE ? IMM_S : opcode == OP_BRANCH ? IMM_B :
                opcode == OP_JAL ? IMM_J : IMM_I;
      case (state)
        FETCH: begin
          alu_src_b = SRC_B_FOUR;
          result_src = RES_ALU;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
        end
        MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        MEM_READ: adr_src = 1'b1;
        MEM_WB: begin
          result_src = RES_MEM;
          reg_write = 1'b1;
        end
        MEM_WRITE: begin
          adr_src = 1'b1;
          mem_write = 1'b1;
        end
        EXEC_R, EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = state == EXEC_I ? SRC_B_IMM : SRC_B_RS2;
          alu_operation = dec_op;
          illegal = dec_bad;
        end
        ALU_WB: reg_write = 1'b1;
        BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_operation = dec_op;
          pc_write = taken;
          illegal = dec_bad;
        end
        JAL: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
          pc_write = 1'b1;
        end
        TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction sequences checked against a cycle/count model
module tb_multicycle_control_unit;
  import rv32i_defs::*;
  logic clk = 1'b0, rstn = 1'b0, funct7_5 = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [3:0] status = 4'd0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  alu_opcode_t alu_operation;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .status(status), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_operation(alu_operation), .illegal(illegal)
  );

  // Runs one instruction from FETCH with wf fetch-wait and wm data-wait cycles and checks
  // cycle count, enable pulse counts and the execute-cycle ALU setup against the ISA rules.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] st, input int wf, input int wm, input string name);
    bit ld, sto, r, im, br, jl, ok_alu, ok_br, tk;
    int cyc, e_rw, e_pw, e_il, e_mw, e_seen, e_imm;
    int rw, pw, il, mw, irw, seen, imm_bad;
    logic [1:0] e_sb, e_rs, sb, rs;
    logic [11:0] idle;
    alu_opcode_t e_op, aop;
    ld = op == 7'b0000011; sto = op == 7'b0100011; r = op == 7'b0110011;
    im = op == 7'b0010011; br = op == 7'b1100011; jl = op == 7'b1101111;
    ok_alu = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
    ok_br = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
    tk = ok_br && (f3 == 3'd0 ? st[2] : f3 == 3'd1 ? !st[2] : f3 == 3'd4 ? st[3] != st[0] : st[3] == st[0]);
    e_pw = 1; e_rw = 0; e_il = 0; e_mw = 0; e_seen = 0; e_imm = -1;
    e_op = SUM; e_sb = 2'b00; e_rs = 2'b00; cyc = wf + 3;
    if (ld) begin
      cyc = wf + wm + 5; e_rw = 1; e_seen = 1; e_sb = 2'b01; e_rs = 2'b01; e_imm = 0;
    end else if (sto) begin
      cyc = wf + wm + 4; e_mw = wm + 1; e_seen = 1; e_sb = 2'b01; e_imm = 1;
    end else if (r || im) begin
      e_seen = 1; e_sb = im ? 2'b01 : 2'b00;
      if (im) e_imm = 0;
      if (ok_alu) begin
        cyc = wf + 4; e_rw = 1;
        e_op = f3 == 3'd0 ? ((r && f7) ? SUB : SUM) : f3 == 3'd2 ? SLT : f3 == 3'd6 ? OR : AND;
      end else e_il = 1;
    end else if (br) begin
      e_pw = tk ? 2 : 1; e_il = ok_br ? 0 : 1; e_seen = 1; e_op = SUB; e_imm = 2;
    end else if (jl) begin
      cyc = wf + 4; e_pw = 2; e_rw = 1; e_imm = 3;
    end else e_il = 1;
    opcode = op; funct3 = f3; funct7_5 = f7; status = st;
    rw = 0; pw = 0; il = 0; mw = 0; irw = 0; seen = 0; imm_bad = 0;
    sb = 2'b11; rs = 2'b11; aop = SUM;
    for (int i = 0; i < cyc; i++) begin
      mem_ready = i < wf ? 1'b0 : i == wf ? 1'b1 :
                  ((ld || sto) && i >= wf + 3) ? (i == wf + 3 + wm) : 1'($urandom_range(0, 1));
      #1;
      rw += int'(reg_write); pw += int'(pc_write); il += int'(illegal);
      mw += int'(mem_write); irw += int'(ir_write);
      if (alu_src_a == 2'b10) begin
        seen++; aop = alu_operation; sb = alu_src_b;
      end
      if (reg_write) rs = result_src;
      if (e_imm >= 0 && imm_src != 2'(e_imm)) imm_bad++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    idle = {ir_write, pc_write, adr_src, mem_write, reg_write, illegal, alu_src_a, alu_src_b, result_src};
    total++; if (idle !== 12'b000000_00_10_10) begin bad++; $display("FAIL %s back_in_fetch got=%b want=000000001010 after %0d cycles", name, idle, cyc); end
    total++; if (rw != e_rw) begin bad++; $display("FAIL %s reg_write_pulses got=%0d want=%0d", name, rw, e_rw); end
    total++; if (pw != e_pw) begin bad++; $display("FAIL %s pc_write_pulses got=%0d want=%0d", name, pw, e_pw); end
    total++; if (il != e_il) begin bad++; $display("FAIL %s illegal_cycles got=%0d want=%0d", name, il, e_il); end
    total++; if (mw != e_mw) begin bad++; $display("FAIL %s mem_write_cycles got=%0d want=%0d", name, mw, e_mw); end
    total++; if (irw != 1) begin bad++; $display("FAIL %s ir_write_pulses got=%0d want=1", name, irw); end
    total++; if (seen != e_seen) begin bad++; $display("FAIL %s rs1_alu_cycles got=%0d want=%0d", name, seen, e_seen); end
    total++; if (imm_bad != 0) begin bad++; $display("FAIL %s imm_src_wrong_cycles got=%0d want=0", name, imm_bad); end
    if (e_seen == 1) begin
      total++; if (aop !== e_op) begin bad++; $display("FAIL %s alu_operation got=%s want=%s", name, aop.name(), e_op.name()); end
      total++; if (sb !== e_sb) begin bad++; $display("FAIL %s alu_src_b got=%b want=%b", name, sb, e_sb); end
    end
    if (e_rw == 1) begin
      total++; if (rs !== e_rs) begin bad++; $display("FAIL %s wb_result_src got=%b want=%b", name, rs, e_rs); end
    end
  endtask

  task automatic test_reset();
    logic [16:0] v;
    rstn = 1'b0; mem_ready = 1'b1; opcode = 7'b1101111;
    #2;
    v = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal, result_src, alu_src_a, alu_src_b, imm_src, alu_operation};
    total++; if (v !== 17'd0) begin bad++; $display("FAIL reset_outputs got=%b want=0", v); end
    @(negedge clk);
    rstn = 1'b1; opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if ({mem_write, adr_src} !== 2'b11) begin bad++; $display("FAIL mid_store_write got=%b want=11", {mem_write, adr_src}); end
    rstn = 1'b0;
    #1;
    v = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal, result_src, alu_src_a, alu_src_b, imm_src, alu_operation};
    total++; if (v !== 17'd0) begin bad++; $display("FAIL async_reset_outputs got=%b want=0", v); end
    @(negedge clk);
    rstn = 1'b1; mem_ready = 1'b1;
    #1;
    total++; if ({ir_write, pc_write, alu_src_b, result_src} !== 6'b111010) begin bad++; $display("FAIL after_reset_fetch got=%b want=111010", {ir_write, pc_write, alu_src_b, result_src}); end
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    run_instr(7'b0110011, 3'b000, 1'b0, 4'($urandom), 0, 0, "add");
    run_instr(7'b0110011, 3'b000, 1'b1, 4'($urandom), 0, 0, "sub");
    run_instr(7'b0010011, 3'b010, 1'b0, 4'($urandom), 0, 0, "slti");
    run_instr(7'b0010011, 3'b000, 1'b1, 4'($urandom), 1, 0, "addi_b30");
    run_instr(7'b0110011, 3'b110, 1'b0, 4'($urandom), 0, 0, "or");
    run_instr(7'b0010011, 3'b111, 1'b0, 4'($urandom), 2, 0, "andi");
  endtask

  task automatic test_load_store();
    run_instr(7'b0000011, 3'b010, 1'b0, 4'($urandom), 0, 3, "lw_wait3");
    run_instr(7'b0100011, 3'b010, 1'b0, 4'($urandom), 0, 2, "sw_wait2");
    run_instr(7'b0000011, 3'b010, 1'b0, 4'($urandom), 2, 0, "lw_fetchwait");
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 1'b0, 4'b0100, 0, 0, "beq_taken");
    run_instr(7'b1100011, 3'b000, 1'b0, 4'b0000, 0, 0, "beq_not");
    run_instr(7'b1100011, 3'b100, 1'b0, 4'b1000, 0, 0, "blt_taken");
    run_instr(7'b1100011, 3'b101, 1'b0, 4'b1001, 0, 0, "bge_taken");
    run_instr(7'b1100011, 3'b001, 1'b0, 4'b0100, 0, 0, "bne_not");
    run_instr(7'b1100011, 3'b110, 1'b0, 4'b0100, 0, 0, "bltu_illegal");
    run_instr(7'b1101111, 3'b000, 1'b0, 4'($urandom), 0, 0, "jal");
  endtask

  task automatic test_trap();
    run_instr(7'b0000000, 3'b000, 1'b0, 4'($urandom), 0, 0, "trap_op0");
    run_instr(7'b0110011, 3'b001, 1'b0, 4'($urandom), 0, 0, "sll_illegal");
    run_instr(7'b0010011, 3'b101, 1'b1, 4'($urandom), 1, 0, "srai_illegal");
  endtask

  task automatic test_random(input int n, input int max_wf, input int max_wm);
    logic [6:0] ops [6];
    logic [6:0] op;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int k = 0; k < n; k++) begin
      op = $urandom_range(0, 7) == 0 ? 7'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(op, 3'($urandom), 1'($urandom), 4'($urandom),
                int'($urandom_range(0, max_wf)), int'($urandom_range(0, max_wm)), "random");
    end
  endtask

  task automatic test_back_to_back();
    test_random(20, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_trap();
    test_random(60, 2, 3);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
